// File: rtl/tentmap_key_scheduler.sv
// Drives the external tentMap engine from a seed, discards warm-up iterates and
// presents each following iterate through a one-entry valid/ready key register.
module tentmap_key_scheduler #(
  parameter int KEY_W = 80,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [KEY_W-1:0] Seed,
  input  logic [CNT_W-1:0] Warmup,
  input  logic [CNT_W-1:0] Num_keys,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [KEY_W-1:0] Key_out,
  output logic             Key_valid,
  input  logic             Key_ready,
  output logic             tm_run,
  output logic [KEY_W-1:0] tm_in,
  input  logic [KEY_W-1:0] tm_out,
  input  logic             tm_done
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, RELEASE, STORE, DRAIN, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] x_q, x_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_vld_q, key_vld_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             error_q, error_d;
  logic             done_q;
  logic             handshake;

  assign handshake = key_vld_q && Key_ready;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q;
    warm_cnt_d = warm_cnt_q;
    iter_cnt_d = iter_cnt_q;
    out_cnt_d  = out_cnt_q;
    error_d    = error_q;
    tm_run     = 1'b0;

    // Consumer handoff can happen in any state; a STORE load below overrides the clear.
    if (handshake) begin
      key_vld_d = 1'b0;
      if (out_cnt_q != '0) out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          x_d        = Seed;
          warm_cnt_d = Warmup;
          iter_cnt_d = Num_keys;
          out_cnt_d  = Num_keys;
          error_d    = 1'b0;
          state_d    = (Num_keys == '0) ? FINISH : LAUNCH;
        end
      end
      LAUNCH: begin
        tm_run = 1'b1;
        if (tm_done) begin
          x_d     = tm_out;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Engine must drop done (back in LOAD) before it may see Run again.
        if (!tm_done) begin
          if (x_q == '0) begin
            error_d   = 1'b1;
            key_vld_d = 1'b0;
            state_d   = FINISH;
          end else if (warm_cnt_q != '0) begin
            warm_cnt_d = warm_cnt_q - CNT_W'(1);
            state_d    = LAUNCH;
          end else begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        if (!key_vld_q || Key_ready) begin
          key_d     = x_q;
          key_vld_d = 1'b1;
          if (iter_cnt_q != '0) iter_cnt_d = iter_cnt_q - CNT_W'(1);
          state_d = (iter_cnt_q > CNT_W'(1)) ? LAUNCH : DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt_q == '0) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      key_q      <= '0;
      key_vld_q  <= 1'b0;
      warm_cnt_q <= '0;
      iter_cnt_q <= '0;
      out_cnt_q  <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      warm_cnt_q <= warm_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      out_cnt_q  <= out_cnt_d;
      error_q    <= error_d;
      done_q     <= (state_q == FINISH);
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Error     = error_q;
  assign Key_out   = key_q;
  assign Key_valid = key_vld_q;
  assign tm_in     = x_q;

endmodule

// File: tb/tb_tentmap_key_scheduler.sv
// Bench for tentmap_key_scheduler: behavioural tentMap engine (mu = 1.5) plus a
// key-list reference model; directed scenarios followed by randomized runs.
module tb_tentmap_key_scheduler;

  localparam logic [79:0] ONE   = 80'h8000_0000_0000_0000_0000;
  localparam logic [79:0] HALF  = 80'h4000_0000_0000_0000_0000;
  localparam logic [79:0] QUART = 80'h2000_0000_0000_0000_0000;
  localparam logic [79:0] KEY_A = 80'h4800_0000_0000_0000_0000;
  localparam logic [79:0] KEY_B = 80'h5400_0000_0000_0000_0000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [79:0] Seed = '0;
  logic [15:0] Warmup = '0;
  logic [15:0] Num_keys = '0;
  logic        Key_ready = 1'b0;
  logic        Busy, Done, Error, Key_valid, tm_run, tm_done;
  logic [79:0] Key_out, tm_in, tm_out;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  tentmap_key_scheduler #(.KEY_W(80), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Seed(Seed), .Warmup(Warmup),
    .Num_keys(Num_keys), .Busy(Busy), .Done(Done), .Error(Error),
    .Key_out(Key_out), .Key_valid(Key_valid), .Key_ready(Key_ready),
    .tm_run(tm_run), .tm_in(tm_in), .tm_out(tm_out), .tm_done(tm_done)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Tent map with mu = 1.5 on Q1.79 values.
  function automatic logic [79:0] tent(input logic [79:0] x);
    logic [79:0] d;
    if (x < HALF) return x + (x >> 1);
    d = ONE - x;
    return d + (d >> 1);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Behavioural engine: LOAD -> compute for a random number of cycles -> HOLD done until Run drops.
  typedef enum {E_LOAD, E_CALC, E_HOLD} eph_e;
  eph_e        eph;
  int          ecnt;
  logic [79:0] ein;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      eph <= E_LOAD; ecnt <= 0; ein <= '0; tm_done <= 1'b0; tm_out <= '0;
    end else begin
      case (eph)
        E_LOAD: if (tm_run) begin
          ein <= tm_in; ecnt <= int'($urandom_range(1, 6)); eph <= E_CALC;
        end
        E_CALC: if (ecnt <= 1) begin
          tm_out <= tent(ein); tm_done <= 1'b1; eph <= E_HOLD;
        end else ecnt <= ecnt - 1;
        default: if (!tm_run) begin
          tm_done <= 1'b0; eph <= E_LOAD;
        end
      endcase
    end
  end

  // Monitor: collects handed-off keys and event counts; checks the output register holds while stalled.
  logic [79:0] got_q[$];
  int          done_cnt = 0, run_seen = 0, valid_seen = 0;
  logic        prev_stall = 1'b0;
  logic [79:0] prev_key = '0;

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (Key_valid && Key_ready) got_q.push_back(Key_out);
      if (Done) done_cnt++;
      if (tm_run) run_seen++;
      if (Key_valid) valid_seen++;
      if (prev_stall) chk("key_hold", Key_out, prev_key);
      prev_stall = Key_valid && !Key_ready;
      prev_key   = Key_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // mode 0: always ready, 1: random ready, 2: ready low for 50 cycles after first valid.
  task automatic run_job(input string tag, input logic [79:0] seed, input int warm, input int nk,
                         input int mode, input bit poke, output int g0);
    logic [79:0] x;
    logic [79:0] exp_q[$];
    bit          exp_err;
    int          d0, v0, cyc, hold, n;
    exp_err = 1'b0;
    x = seed;
    for (int i = 0; i < warm + nk; i++) begin
      x = tent(x);
      if (x == '0) begin exp_err = 1'b1; break; end
      if (i >= warm) exp_q.push_back(x);
    end
    g0 = got_q.size(); d0 = done_cnt; v0 = valid_seen;
    Seed = seed; Warmup = 16'(warm); Num_keys = 16'(nk); Start = 1'b1;
    Key_ready = (mode == 0);
    tick();
    Start = 1'b0; Seed = {16'h0, $urandom(), $urandom()}; Warmup = 16'($urandom); Num_keys = 16'($urandom);
    cyc = 0; hold = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      Start = poke && (cyc == 4);
      case (mode)
        0: Key_ready = 1'b1;
        1: Key_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hold < 50) begin
            Key_ready = 1'b0;
            if (Key_valid) hold++;
            if (hold == 50) begin
              chk({tag, "_stall_key"}, Key_out, exp_q[0]);
              chk({tag, "_stall_vld"}, 80'(Key_valid), 80'(1));
              chk({tag, "_stall_run"}, 80'(tm_run), 80'(0));
              chk({tag, "_stall_busy"}, 80'(Busy), 80'(1));
            end
          end else Key_ready = 1'b1;
        end
      endcase
      tick();
      cyc++;
    end
    Start = 1'b0;
    chk({tag, "_timeout"}, 80'(cyc < 20000), 80'(1));
    tick(); tick();
    n = got_q.size() - g0;
    chk({tag, "_done_cnt"}, 80'(done_cnt - d0), 80'(1));
    chk({tag, "_error"}, 80'(Error), 80'(exp_err));
    chk({tag, "_nkeys"}, 80'(n), 80'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({tag, "_key"}, got_q[g0 + i], exp_q[i]);
    if (exp_q.size() == 0) chk({tag, "_no_valid"}, 80'(valid_seen - v0), 80'(0));
    chk({tag, "_idle"}, 80'({Busy, Key_valid, tm_run}), 80'(0));
  endtask

  initial begin
    int g0, cyc, r0, w, nk;
    logic [95:0] r;
    logic [79:0] s;

    // Reset state
    tick(); tick();
    chk("rst_outs", 80'({Busy, Done, Error, Key_valid, tm_run}), 80'(0));
    chk("rst_key", Key_out, 80'(0));
    chk("rst_tm_in", tm_in, 80'(0));
    Reset_n = 1'b1;
    tick();
    chk("post_rst_busy", 80'(Busy), 80'(0));

    // Scenario 1: nominal run with literal key values
    run_job("s1", QUART, 1, 2, 0, 1'b0, g0);
    if (got_q.size() >= g0 + 2) begin
      chk("s1_keyA", got_q[g0], KEY_A);
      chk("s1_keyB", got_q[g0 + 1], KEY_B);
    end

    // Scenario 2: consumer stalls after the first key
    run_job("s2", QUART, 1, 2, 2, 1'b0, g0);
    if (got_q.size() >= g0 + 2) begin
      chk("s2_keyA", got_q[g0], KEY_A);
      chk("s2_keyB", got_q[g0 + 1], KEY_B);
    end

    // Scenario 3: first iterate is zero
    run_job("s3", ONE, 0, 4, 0, 1'b0, g0);
    chk("s3_run_low", 80'(tm_run), 80'(0));

    // Error clears on the next accepted Start
    run_job("s3b", QUART, 0, 1, 0, 1'b0, g0);

    // Scenario 4: Num_keys = 0
    r0 = run_seen;
    Seed = QUART; Warmup = 16'd3; Num_keys = 16'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("nk0_busy", 80'(Busy), 80'(1));
    chk("nk0_done_early", 80'(Done), 80'(0));
    tick();
    chk("nk0_busy_off", 80'(Busy), 80'(0));
    chk("nk0_done", 80'(Done), 80'(1));
    tick();
    chk("nk0_done_off", 80'(Done), 80'(0));
    chk("nk0_no_run", 80'(run_seen - r0), 80'(0));

    // Scenario 5: reset while LAUNCH is in flight with a key pending
    Key_ready = 1'b0; Seed = QUART; Warmup = 16'd1; Num_keys = 16'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 0;
    while (!(Key_valid && tm_run) && cyc < 2000) begin tick(); cyc++; end
    chk("s5_reach_launch", 80'(cyc < 2000), 80'(1));
    #3 Reset_n = 1'b0;
    #1;
    chk("s5_rst_outs", 80'({Busy, Done, Error, Key_valid, tm_run}), 80'(0));
    chk("s5_rst_key", Key_out, 80'(0));
    chk("s5_rst_tm_in", tm_in, 80'(0));
    tick();
    Reset_n = 1'b1;
    tick();
    run_job("s5", QUART, 1, 2, 0, 1'b0, g0);
    if (got_q.size() >= g0 + 2) begin
      chk("s5_keyA", got_q[g0], KEY_A);
      chk("s5_keyB", got_q[g0 + 1], KEY_B);
    end

    // Scenario 6: Start pulsed while busy is ignored
    run_job("s6", QUART, 1, 2, 0, 1'b1, g0);

    // Randomized runs: seeds in (0, 1) never reach zero under this map
    for (int k = 0; k < 10; k++) begin
      r = {$urandom(), $urandom(), $urandom()};
      s = {1'b0, r[78:0]};
      if (s == '0) s = 80'd1;
      w  = int'($urandom_range(0, 6));
      nk = int'($urandom_range(1, 6));
      run_job("rnd", s, w, nk, 1, 1'($urandom_range(0, 1)), g0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tentmap_key_scheduler.md
Name: tentmap_key_scheduler

Overview:
- Sequences the tentMap engine to turn one 80-bit seed into a stream of 80-bit chaotic keys for the video encryption datapath.
- Drives the engine's Run/in/out/done handshake and feeds each iterate back as the next input.
- Discards a programmable number of warm-up iterates, then delivers each following iterate through a one-entry valid/ready output register.
- Sits between the encryption control FSM (Start/Done) and the pixel XOR stage (key consumer).

Parameters:
- KEY_W, 80: key/iterate width, Q1.79 fixed point (80'h8000...0 = 1.0).
- CNT_W, 16: width of the warm-up and key counters.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin a run; sampled only in IDLE.
- Seed  in  KEY_W  initial iterate; latched on accepted Start.
- Warmup  in  CNT_W  iterates to discard; latched on Start.
- Num_keys  in  CNT_W  keys to deliver; latched on Start.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the run ends (normal or error).
- Error  out  1  sticky; set when an iterate equals 0; cleared on the next accepted Start.
- Key_out  out  KEY_W  output register contents.
- Key_valid  out  1  output register full.
- Key_ready  in  1  consumer accepts Key_out when Key_valid && Key_ready.
- tm_run  out  1  to tentMap Run.
- tm_in  out  KEY_W  to tentMap in; always equals internal iterate register x.
- tm_out  in  KEY_W  from tentMap out.
- tm_done  in  1  from tentMap done.

Behaviour:
- Reset (async, any state, including mid-iteration):
  - State goes to IDLE.
  - x, all counters, Key_out, Key_valid, Done, Error and tm_run are cleared to 0.
  - The engine is reset by the same system reset, inverted at top level.
- Internal registers: x, warm_cnt, iter_cnt (keys still to produce), out_cnt (keys still to hand off).
- IDLE:
  - On Start: x<=Seed, warm_cnt<=Warmup, iter_cnt<=Num_keys, out_cnt<=Num_keys, Error<=0.
  - If Num_keys==0, go to FINISH; otherwise go to LAUNCH.
- LAUNCH:
  - tm_run=1.
  - Wait for tm_done==1, then x<=tm_out and go to RELEASE.
- RELEASE:
  - tm_run=0.
  - Wait for tm_done==0, so the engine is back in LOAD before the next Run.
  - Then evaluate in this priority order:
    1. x==0: set Error, go to FINISH. Key_valid is dropped; pending key is discarded.
    2. warm_cnt!=0: decrement warm_cnt, go to LAUNCH.
    3. Otherwise go to STORE.
- STORE:
  - If Key_valid==0, or a handshake occurs this cycle: Key_out<=x, Key_valid<=1, decrement iter_cnt.
    - If the new iter_cnt!=0, go to LAUNCH; otherwise go to DRAIN.
  - Else remain in STORE (back-pressure). tm_run stays 0.
- DRAIN: wait until out_cnt==0, then go to FINISH.
- FINISH: Done=1 for exactly one cycle, go to IDLE.
- Output register rules:
  - Each handshake clears Key_valid (unless reloaded the same cycle) and decrements out_cnt.
  - Key_out is stable while Key_valid && !Key_ready.
  - Simultaneous handshake and STORE load: the new key replaces the old one, Key_valid stays 1, and there is no bubble.
- Overlap: the next iteration (LAUNCH) runs while the previous key waits in the output register.
- Ignored inputs: Start is ignored while Busy. Seed, Warmup and Num_keys are ignored outside the Start cycle.
- Latency:
  - Per iterate: tentMap latency (LOAD, ADJUST, COMPUTE until mult_done, HOLD) + 1 cycle capture + 1–2 cycles RELEASE.
  - First Key_valid appears (Warmup+1) iterations after Start.
- Width: no arithmetic on iterates. Counters never decrement below 0.

Test Plan:
- Seed=80'h2000...0 (0.25), Warmup=1, Num_keys=2, Key_ready=1:
  - 0x3000...0 is discarded.
  - Keys are 80'h4800...0 then 80'h5400...0.
  - Done pulses once; Error=0.
- Same run with Key_ready=0 for 50 cycles after the first Key_valid:
  - Key_out holds 80'h4800...0 and the scheduler waits in STORE.
  - After Key_ready rises, 80'h5400...0 follows.
  - Exactly 2 handshakes.
- Seed=80'h8000...0 (1.0), Num_keys=4:
  - First iterate is 0, so Error=1 and Done pulses.
  - No Key_valid; tm_run ends low.
- Num_keys=0:
  - Done pulses 2 cycles after Start.
  - tm_run never asserts; Busy high for 1 cycle.
- Reset_n low while in LAUNCH:
  - All outputs 0 immediately; state is IDLE.
  - A new Start with Seed=80'h2000...0 reproduces scenario 1 exactly.
- Start pulsed while Busy: ignored; key count and values unchanged.
